// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle arithmetic/logic plus iterative
// shifts, rotates and a shift-add multiplier, with results held until retired.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             illegal,
    output logic             busy
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_LSH = 4'd5;
    localparam logic [3:0] OP_RSH = 4'd6;
    localparam logic [3:0] OP_ASR = 4'd7;
    localparam logic [3:0] OP_ROL = 4'd8;
    localparam logic [3:0] OP_ROR = 4'd9;
    localparam logic [3:0] OP_MUL = 4'd10;

    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t                 state, state_next;
    logic [3:0]             op_r;
    logic [WIDTH-1:0]       work;
    logic [WIDTH-1:0]       cnt;
    logic [2*WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]     acc;

    logic                   accept;
    logic                   is_shift, is_rot, multi;
    logic [WIDTH-1:0]       amt;
    logic [WIDTH:0]         sum;
    logic [WIDTH-1:0]       diff;
    logic [WIDTH-1:0]       imm_out;
    logic                   imm_carry, imm_ovf, imm_ill;
    logic [WIDTH-1:0]       sh_next;
    logic                   sh_bit;
    logic [2*WIDTH-1:0]     acc_next;
    logic                   last;
    logic                   res_load;
    logic [WIDTH-1:0]       res_out;
    logic                   res_carry, res_ovf, res_ill;

    // in_ready looks through to out_ready in DONE so results can stream back-to-back
    assign in_ready  = !reset && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == EXEC);
    assign negative  = out[WIDTH-1];

    always_comb begin
        sum       = {1'b0, in1} + {1'b0, in2};
        diff      = in1 - in2;
        is_shift  = (op >= OP_LSH) && (op <= OP_ROR);
        is_rot    = (op == OP_ROL) || (op == OP_ROR);
        amt       = is_rot ? (in2 % W_VAL) : ((in2 > W_VAL) ? W_VAL : in2);
        multi     = (op == OP_MUL) || (is_shift && (amt != '0));
        imm_out   = '0;
        imm_carry = 1'b0;
        imm_ovf   = 1'b0;
        imm_ill   = 1'b0;
        case (op)
            OP_ADD: begin
                imm_out   = sum[WIDTH-1:0];
                imm_carry = sum[WIDTH];
                imm_ovf   = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SUB: begin
                imm_out   = diff;
                imm_carry = (in1 < in2);
                imm_ovf   = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_AND: imm_out = in1 & in2;
            OP_OR:  imm_out = in1 | in2;
            OP_XOR: imm_out = in1 ^ in2;
            OP_LSH, OP_RSH, OP_ASR, OP_ROL, OP_ROR: imm_out = in1;
            OP_MUL: imm_out = '0;
            default: imm_ill = 1'b1;
        endcase
    end

    // One bit per EXEC cycle; sh_bit is the bit leaving (or wrapping) on this step
    always_comb begin
        sh_next = work;
        sh_bit  = 1'b0;
        case (op_r)
            OP_LSH: begin sh_next = {work[WIDTH-2:0], 1'b0};         sh_bit = work[WIDTH-1]; end
            OP_RSH: begin sh_next = {1'b0, work[WIDTH-1:1]};         sh_bit = work[0];       end
            OP_ASR: begin sh_next = {work[WIDTH-1], work[WIDTH-1:1]}; sh_bit = work[0];      end
            OP_ROL: begin sh_next = {work[WIDTH-2:0], work[WIDTH-1]}; sh_bit = work[WIDTH-1]; end
            OP_ROR: begin sh_next = {work[0], work[WIDTH-1:1]};      sh_bit = work[0];       end
            default: ;
        endcase
        acc_next = acc + (work[0] ? mcand : '0);
        last     = (cnt == WIDTH'(1));
    end

    always_comb begin
        state_next = state;
        res_load   = 1'b0;
        res_out    = imm_out;
        res_carry  = imm_carry;
        res_ovf    = imm_ovf;
        res_ill    = imm_ill;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    state_next = multi ? EXEC : DONE;
                    res_load   = !multi;
                end else if ((state == DONE) && out_ready) begin
                    state_next = IDLE;
                end
            end
            EXEC: begin
                if (last) begin
                    state_next = DONE;
                    res_load   = 1'b1;
                    res_ovf    = 1'b0;
                    res_ill    = 1'b0;
                    if (op_r == OP_MUL) begin
                        res_out   = acc_next[WIDTH-1:0];
                        res_carry = |acc_next[2*WIDTH-1:WIDTH];
                    end else begin
                        res_out   = sh_next;
                        res_carry = sh_bit;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result registers load only on DONE entry so they stay frozen through EXEC
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            op_r     <= '0;
            work     <= '0;
            cnt      <= '0;
            mcand    <= '0;
            acc      <= '0;
            out      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_r  <= op;
                work  <= (op == OP_MUL) ? in2 : in1;
                cnt   <= (op == OP_MUL) ? W_VAL : amt;
                mcand <= {{WIDTH{1'b0}}, in1};
                acc   <= '0;
            end else if (state == EXEC) begin
                cnt   <= cnt - WIDTH'(1);
                work  <= (op_r == OP_MUL) ? (work >> 1) : sh_next;
                mcand <= mcand << 1;
                acc   <= acc_next;
            end
            if (res_load) begin
                out      <= res_out;
                carry    <= res_carry;
                overflow <= res_ovf;
                illegal  <= res_ill;
                zero     <= (res_out == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed and random checks of alu_seq against a behavioural reference,
// using a scoreboard of expected results and latencies.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [7:0] in1;
    logic [7:0] in2;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out;
    logic       carry, overflow, zero, negative, illegal, busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] out;
        logic       carry;
        logic       ovf;
        logic       ill;
        int         lat;
    } exp_t;

    exp_t sb[$];

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .carry(carry), .overflow(overflow), .zero(zero),
        .negative(negative), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic exp_t model(logic [3:0] o, logic [7:0] a, logic [7:0] b);
        exp_t e;
        int n;
        int sv;
        logic [15:0] d;
        logic signed [15:0] ds;
        logic [15:0] p;
        e.out = 8'h00; e.carry = 1'b0; e.ovf = 1'b0; e.ill = 1'b0; e.lat = 1;
        n = (o == 4'd8 || o == 4'd9) ? int'(b) % 8 : ((int'(b) > 8) ? 8 : int'(b));
        case (o)
            4'd0: begin
                sv = int'(a) + int'(b);
                e.out = sv[7:0]; e.carry = (sv > 255);
                sv = int'($signed(a)) + int'($signed(b));
                e.ovf = (sv > 127) || (sv < -128);
            end
            4'd1: begin
                sv = int'(a) - int'(b);
                e.out = sv[7:0]; e.carry = (a < b);
                sv = int'($signed(a)) - int'($signed(b));
                e.ovf = (sv > 127) || (sv < -128);
            end
            4'd2: e.out = a & b;
            4'd3: e.out = a | b;
            4'd4: e.out = a ^ b;
            4'd5: begin d = {8'h00, a} << n; e.out = d[7:0];  e.carry = (n > 0) && d[8]; end
            4'd6: begin d = {a, 8'h00} >> n; e.out = d[15:8]; e.carry = (n > 0) && d[7]; end
            4'd7: begin ds = $signed({a, 8'h00}) >>> n; e.out = ds[15:8]; e.carry = (n > 0) && ds[7]; end
            4'd8: begin d = {a, a} << n; e.out = d[15:8]; e.carry = (n > 0) && e.out[0]; end
            4'd9: begin d = {a, a} >> n; e.out = d[7:0];  e.carry = (n > 0) && e.out[7]; end
            4'd10: begin
                p = 16'(a) * 16'(b);
                e.out = p[7:0]; e.carry = |p[15:8]; e.lat = 9;
            end
            default: e.ill = 1'b1;
        endcase
        if (o >= 4'd5 && o <= 4'd9) e.lat = 1 + n;
        return e;
    endfunction

    task automatic check_output(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_result(string tag, exp_t e, int lat);
        check_output({tag, "_out"},  out,      e.out);
        check_output({tag, "_cy"},   carry,    e.carry);
        check_output({tag, "_ov"},   overflow, e.ovf);
        check_output({tag, "_zero"}, zero,     (e.out == 8'h00));
        check_output({tag, "_neg"},  negative, e.out[7]);
        check_output({tag, "_ill"},  illegal,  e.ill);
        if (lat >= 0) check_output({tag, "_lat"}, lat, e.lat);
    endtask

    task automatic apply_stimulus(logic [3:0] o, logic [7:0] a, logic [7:0] b);
        in_valid = 1'b1;
        op  = o;
        in1 = a;
        in2 = b;
        sb.push_back(model(o, a, b));
    endtask

    task automatic pop_expected(string tag, output exp_t e);
        check_output({tag, "_sb"}, sb.size(), 1);
        if (sb.size() > 0) e = sb.pop_front();
        else e = model(4'd15, 8'h00, 8'h00);
    endtask

    // Issue one op from IDLE, measure latency, optionally backpressure, then retire
    task automatic run_op(string tag, logic [3:0] o, logic [7:0] a, logic [7:0] b,
                          int hold, output int busy_cycles);
        int   lat;
        logic ready_seen;
        exp_t e;
        check_output({tag, "_rdy"}, in_ready, 1);
        out_ready = 1'b0;
        apply_stimulus(o, a, b);
        @(posedge clk); #1;
        in_valid    = 1'b0;
        lat         = 1;
        busy_cycles = 0;
        ready_seen  = 1'b0;
        while (!out_valid && lat < 60) begin
            if (busy) busy_cycles++;
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check_output({tag, "_vld"}, out_valid, 1);
        check_output({tag, "_exec_rdy"}, ready_seen, 0);
        pop_expected(tag, e);
        compare_result(tag, e, lat);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            op  = 4'd0;
            in1 = 8'($urandom);
            in2 = 8'($urandom);
            @(posedge clk); #1;
            check_output({tag, "_hold_vld"}, out_valid, 1);
            check_output({tag, "_hold_rdy"}, in_ready, 0);
            compare_result({tag, "_hold"}, e, -1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_output({tag, "_retired"}, out_valid, 0);
    endtask

    task automatic check_output_reset(string tag);
        check_output({tag, "_rdy"},  in_ready,  0);
        check_output({tag, "_vld"},  out_valid, 0);
        check_output({tag, "_out"},  out,       0);
        check_output({tag, "_cy"},   carry,     0);
        check_output({tag, "_ov"},   overflow,  0);
        check_output({tag, "_zero"}, zero,      0);
        check_output({tag, "_neg"},  negative,  0);
        check_output({tag, "_ill"},  illegal,   0);
        check_output({tag, "_busy"}, busy,      0);
    endtask

    initial begin
        int   bc;
        int   seen;
        exp_t e;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = 4'd0; in1 = 8'h00; in2 = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_output_reset("reset");
        reset = 1'b0;
        @(negedge clk);
        check_output("post_reset_rdy", in_ready, 1);

        run_op("add_ovf",  4'd0, 8'h7F, 8'h01, 0, bc);
        run_op("sub_brw",  4'd1, 8'h03, 8'h05, 0, bc);
        run_op("add_cy",   4'd0, 8'hFF, 8'h01, 0, bc);
        run_op("and",      4'd2, 8'hF0, 8'h3C, 0, bc);
        run_op("or",       4'd3, 8'h81, 8'h18, 0, bc);
        run_op("xor",      4'd4, 8'hAA, 8'hAA, 0, bc);
        run_op("lsh3",     4'd5, 8'h81, 8'd3, 0, bc);
        check_output("lsh3_busy", bc, 3);
        run_op("asr9",     4'd7, 8'h80, 8'd9, 0, bc);
        run_op("ror9",     4'd9, 8'h01, 8'd9, 0, bc);
        run_op("mul_hi",   4'd10, 8'h10, 8'h11, 0, bc);
        check_output("mul_busy", bc, 8);
        run_op("mul_lo",   4'd10, 8'h0F, 8'h03, 0, bc);
        run_op("lsh8",     4'd5, 8'h01, 8'd8, 0, bc);
        run_op("rsh8",     4'd6, 8'h80, 8'd200, 0, bc);
        run_op("rsh0",     4'd6, 8'h5A, 8'd0, 0, bc);
        run_op("rol8",     4'd8, 8'hC3, 8'd8, 0, bc);
        run_op("rol3",     4'd8, 8'hB1, 8'd3, 0, bc);
        run_op("illegal",  4'd15, 8'h12, 8'h34, 0, bc);
        run_op("bp_add",   4'd0, 8'h55, 8'h22, 5, bc);

        // Five back-to-back ADDs streaming through DONE
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(4'd0, 8'(8'h40 + i * 8'h20), 8'(8'h30 + i));
            @(posedge clk); #1;
            check_output("b2b_vld", out_valid, 1);
            pop_expected("b2b", e);
            compare_result("b2b", e, -1);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check_output("b2b_drain", out_valid, 0);
        out_ready = 1'b0;

        // Abort a MUL with reset on its 4th EXEC cycle
        in_valid = 1'b1; op = 4'd10; in1 = 8'h77; in2 = 8'h99;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("abort_busy", busy, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_output_reset("abort");
        reset = 1'b0;
        @(negedge clk);
        check_output("abort_rdy", in_ready, 1);
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check_output("abort_discard", seen, 0);

        for (int i = 0; i < 12; i++) begin
            run_op("rand", 4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom_range(0, 10)), 0, bc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the 4-bit ALU. It executes one operation at a time:
- single-cycle ops: add, subtract and bitwise logic;
- multi-cycle ops: barrel-free iterative shifts and rotates, plus a shift-add multiplier.

Results are held with a full flag set. It sits between the instruction decoder (valid/ready source) and the register-file writeback (valid/ready sink).

## Interface
- WIDTH, 8, operand/result width (≥2)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; in_valid&&in_ready = accept
- op  in  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 LSH, 6 RSH (logical), 7 ASR, 8 ROL, 9 ROR, 10 MUL, 11–15 illegal
- in1  in  WIDTH  operand A
- in2  in  WIDTH  operand B / shift amount (unsigned)
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts; out_valid&&out_ready = retire
- out  out  WIDTH  result
- carry  out  1  carry/borrow/last-bit-out
- overflow  out  1  signed overflow
- zero  out  1  out==0
- negative  out  1  out[WIDTH-1]
- illegal  out  1  opcode 11–15
- busy  out  1  state==EXEC

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - EXEC: multi-cycle work.
  - DONE: out_valid=1.
- Accept: on accept, latch op, in1 and in2. Later input changes are ignored.
- Single-cycle ops (0–4, illegal): IDLE→DONE on the accept edge.
- Shifts/rotates (5–9):
  - Effective amount n:
    - LSH/RSH/ASR: min(in2, WIDTH).
    - ROL/ROR: in2 mod WIDTH.
  - n=0 → DONE directly. Result = in1, carry=0.
  - Otherwise IDLE→EXEC with a down-counter of n. One bit is shifted per EXEC cycle. →DONE when the count reaches 0.
- MUL: EXEC for exactly WIDTH cycles, one partial product per cycle, into a 2·WIDTH accumulator.
  - out = low WIDTH bits.
  - carry = 1 if the high WIDTH bits ≠ 0 (unsigned).
- DONE:
  - Holds out and all flags stable until retire.
  - Retire with no simultaneous accept → IDLE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is a combinational path from out_ready; it gives back-to-back throughput.
  - Retire and accept in the same cycle: the new op is latched and the FSM goes to DONE or EXEC directly.
- Flag rules:
  - ADD: carry = unsigned carry-out; overflow = signed overflow.
  - SUB: carry = borrow (in1<in2 unsigned); overflow = signed overflow.
  - AND/OR/XOR: carry=0, overflow=0.
  - LSH: carry = last bit shifted out of the MSB.
  - RSH/ASR: carry = last bit shifted out of the LSB.
  - ROL/ROR: carry = last bit wrapped.
  - Shifts, rotates and MUL: overflow=0.
  - All ops: zero and negative are derived from out.
- ASR fills with the sign bit. For n=WIDTH, out is all sign bits and carry=in1[WIDTH-1].
- LSH/RSH with n=WIDTH: out=0, carry = in1[0] for LSH and in1[WIDTH-1] for RSH.
- Illegal opcode: out=0, carry=overflow=0, illegal=1, zero=1. It is single-cycle.
- illegal=0 for all legal ops.

## Timing
- Reset:
  - While reset is high: state=IDLE, in_ready=0, out_valid=0, out=0, and carry/overflow/zero/negative/illegal/busy=0.
  - in_ready=1 from the first cycle after reset deasserts.
- Reset mid-EXEC or in DONE aborts the op. The result is discarded, never presented.
- Latency, measured from the accept edge to the first cycle out_valid=1:
  - ops 0–4 and illegal: 1 cycle.
  - shifts with n=0: 1 cycle.
  - shifts: 1+n cycles.
  - MUL: 1+WIDTH cycles.
- Result registers update only on the DONE-entry edge. They are unchanged in EXEC.
- in_ready=0 throughout EXEC.

## Test plan
- WIDTH=8, ADD 0x7F+0x01 → 1 cycle later: out=0x80, overflow=1, carry=0, negative=1, zero=0.
- SUB 0x03−0x05 → out=0xFE, carry=1, overflow=0, negative=1. Also ADD 0xFF+0x01 → out=0x00, carry=1, zero=1.
- LSH 0x81 by 3 → out_valid 4 cycles after accept, out=0x08, carry=0, busy=1 for 3 cycles. Also ASR 0x80 by 9 → latency 9, out=0xFF, carry=1. Also ROR 0x01 by 9 → out=0x80, carry=1, latency 2.
- MUL 0x10×0x11 → latency 9, out=0x10, carry=1. Also MUL 0x0F×0x03 → out=0x2D, carry=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE → out and flags stable, in_ready=0.
  - Then five back-to-back ADDs with out_ready=1 → five consecutive out_valid cycles with the correct sums.
- Reset asserted on the 4th EXEC cycle of a MUL → next cycle out_valid=0, outputs 0, in_ready=0. After deassert, in_ready=1. Also opcode 0xF → out=0, illegal=1, zero=1.
